// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, the
// control state enum, the datapath word width and the alignment check.
package lsu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic misaligned(size_e size, logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = |addr_lo;
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response channel between the execute stage (master) and the
// load/store unit (slave).
//   req_*  : byte-addressed load/store request, valid/ready handshake
//   resp_* : load data / completion with error flag, valid/ready handshake
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling for sub-word accesses (little-endian lanes).
//   rd_word, addr_lo, size, is_unsigned -> load_data (extracted + extended)
//   old_word, wdata, addr_lo, size      -> merged (store lane inserted)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word,
  input  logic [1:0]        addr_lo,
  input  size_e             size,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] load_data,
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] merged
);

  function automatic logic [WORD_W-1:0] ext_byte(logic [7:0] b, logic uns);
    logic signed [7:0] sb;
    sb = b;
    ext_byte = uns ? {{(WORD_W-8){1'b0}}, b} : WORD_W'(sb);
  endfunction

  function automatic logic [WORD_W-1:0] ext_half(logic [15:0] h, logic uns);
    logic signed [15:0] sh;
    sh = h;
    ext_half = uns ? {{(WORD_W-16){1'b0}}, h} : WORD_W'(sh);
  endfunction

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rd_word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SIZE_BYTE: load_data = ext_byte(lane_b, is_unsigned);
      SIZE_HALF: load_data = ext_half(lane_h, is_unsigned);
      default:   load_data = rd_word;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (size)
      SIZE_BYTE: merged[{addr_lo, 3'b000} +: 8]  = wdata[7:0];
      SIZE_HALF: merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default:   merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of a word-addressed data memory.
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : byte-addressed request / response channel
//   mem_address      : word index {2'b00, addr[31:2]}
//   mem_write_data   : full word to write
//   mem_write_enable : write strobe, memory writes on the next posedge
//   mem_read_data    : combinational read of mem_address
// Sub-word stores are read-modify-write (ACCESS reads, WRITE writes).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  lsu_if.slave              bus,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [WORD_W-1:0] mem_read_data
);

  state_e            state, state_nxt;
  logic              wr_q, uns_q, err_q;
  size_e             size_q;
  logic [WORD_W-1:0] addr_q, wdata_q, rdata_q, merged_q;

  logic              accept, req_err;
  size_e             req_size_e;
  logic [WORD_W-1:0] load_data, merged;

  assign accept     = bus.req_valid && (state == IDLE);
  assign req_size_e = size_e'(bus.req_size);
  assign req_err    = (req_size_e == SIZE_ILL)
                   || misaligned(req_size_e, bus.req_addr[1:0])
                   || ({2'b00, bus.req_addr[31:2]} >= WORD_W'(MEM_WORDS));

  lsu_lane_align u_align (
    .rd_word     (mem_read_data),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .old_word    (mem_read_data),
    .wdata       (wdata_q),
    .merged      (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = (wr_q && size_q != SIZE_WORD) ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept: latch request fields; rdata cleared so stores/errors return 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size_e;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
      end
      // Access: capture extended load data or the merged store word.
      if (state == ACCESS) begin
        if (!wr_q) rdata_q  <= load_data;
        else       merged_q <= merged;
      end
    end
  end

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.resp_valid   = (state == RESP);
    bus.resp_rdata   = rdata_q;
    bus.resp_error   = err_q;
    mem_address      = {2'b00, addr_q[WORD_W-1:2]};
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    case (state)
      ACCESS: if (wr_q && size_q == SIZE_WORD) begin
        mem_write_data   = wdata_q;
        mem_write_enable = 1'b1;
      end
      WRITE: begin
        mem_write_data   = merged_q;
        mem_write_enable = 1'b1;
      end
      default: ;
    endcase
    // Reset abandons an in-flight store without touching memory.
    if (rst) mem_write_enable = 1'b0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem [0:1023];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (mem_write_enable && mem_address < 32'd1024) begin
      mem[mem_address[9:0]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request (called just after a posedge), follows it to its
  // response, records latency and any write strobe, then accepts the response.
  task automatic do_req(input string nm, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int we_cnt, output logic [31:0] we_addr,
                        output logic [31:0] we_data);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; we_cnt = 0; we_addr = 0; we_data = 0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_write_enable) begin
        we_cnt++;
        we_addr = mem_address;
        we_data = mem_write_data;
      end
      if (bus.resp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_error;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic txn(input string nm, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                     input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_wes, input logic [31:0] exp_wd);
    int lat, wes;
    logic [31:0] rd, wa, wdv;
    logic er;
    do_req(nm, wr, sz, uns, addr, wd, lat, rd, er, wes, wa, wdv);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " error"}, 32'(er), 32'(exp_err));
    chk({nm, " write_count"}, 32'(wes), 32'(exp_wes));
    if (exp_wes > 0) begin
      chk({nm, " write_addr"}, wa, {2'b00, addr[31:2]});
      chk({nm, " write_data"}, wdv, exp_wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; mem_clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset resp_error", 32'(bus.resp_error), 32'd0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset mem_write_data", mem_write_data, 32'h0);
    chk("reset mem_write_enable", 32'(mem_write_enable), 32'd0);
    rst = 1'b0; mem_clr = 1'b0;
    @(posedge clk); #1;

    // Word store then load.
    txn("st_word", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 1, 32'hDEADBEEF);
    chk("st_word mem4", mem[4], 32'hDEADBEEF);
    txn("ld_word", 0, 2'd2, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 0, 32'h0);

    // Byte read-modify-write.
    txn("st_byte", 1, 2'd0, 0, 32'h12, 32'h00000055, 3, 32'h0, 0, 1, 32'hDE55BEEF);
    chk("st_byte mem4", mem[4], 32'hDE55BEEF);

    // Load extension.
    txn("ld_sbyte13", 0, 2'd0, 0, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 0, 0, 32'h0);
    txn("ld_uhalf12", 0, 2'd1, 1, 32'h12, 32'h0, 2, 32'h0000DE55, 0, 0, 32'h0);
    txn("ld_shalf10", 0, 2'd1, 0, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 0, 0, 32'h0);
    txn("ld_ubyte11", 0, 2'd0, 1, 32'h11, 32'h0, 2, 32'h000000BE, 0, 0, 32'h0);

    // Errors and the last in-range word.
    txn("err_word11", 0, 2'd2, 0, 32'h11, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    txn("err_half13", 1, 2'd1, 0, 32'h13, 32'h0000FFFF, 1, 32'h0, 1, 0, 32'h0);
    txn("err_size3", 0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    txn("err_range", 0, 2'd2, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 32'h0);
    txn("ok_last", 0, 2'd2, 0, 32'hFFC, 32'h0, 2, 32'h0, 0, 0, 32'h0);
    chk("err mem4 intact", mem[4], 32'hDE55BEEF);

    // Backpressure.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    w = 0;
    while (!bus.resp_valid && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp resp_valid", 32'(bus.resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp hold valid", 32'(bus.resp_valid), 32'd1);
      chk("bp hold rdata", bus.resp_rdata, 32'hDE55BEEF);
      chk("bp req_ready", 32'(bus.req_ready), 32'd0);
      if (i == 1) begin
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
        bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
      end
      if (i == 2) bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("bp idle req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp idle resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp no store", mem[8], 32'h0);
    txn("bp_next", 0, 2'd2, 0, 32'h20, 32'h0, 2, 32'h0, 0, 0, 32'h0);

    // Reset during the WRITE cycle of a byte store.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h24; bus.req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst access we", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    chk("rst write we before", 32'(mem_write_enable), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst write we forced", 32'(mem_write_enable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst after req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst no resp", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("rst no write", mem[9], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
